// File: rtl/alu_shift_seq.sv
// Multi-cycle shift/rotate unit: walks the operand up to STEP bit positions per
// cycle behind a valid/ready request and response handshake.
module alu_shift_seq #(
  parameter int WIDTH = 32,
  parameter int STEP  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  input  logic [3:0]       req_opcode,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [WIDTH-1:0] resp_result,
  output logic             resp_err,
  output logic             busy
);

  localparam int LW = $clog2(WIDTH);
  localparam logic [LW-1:0] STEP_C = LW'(STEP);

  localparam logic [3:0] OP_SLL = 4'b0101;
  localparam logic [3:0] OP_SAR = 4'b0110;
  localparam logic [3:0] OP_ROL = 4'b0111;
  localparam logic [3:0] OP_ROR = 4'b1000;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] work;
  logic [WIDTH-1:0] res;
  logic [3:0]       op;
  logic [LW-1:0]    cnt;
  logic             err;

  logic             accept;
  logic             legal;
  logic [LW-1:0]    amt;
  logic [LW-1:0]    step_amt;
  logic             last_step;
  logic [WIDTH-1:0] shifted;
  logic             unused_b;

  // One partial move of s positions (1..STEP); s is never 0 while shifting.
  function automatic logic [WIDTH-1:0] shift_step(input logic [WIDTH-1:0] w,
                                                  input logic [3:0]       opc,
                                                  input logic [LW-1:0]    s);
    logic signed [WIDTH-1:0] ws;
    ws = w;
    case (opc)
      OP_SLL:  return w << s;
      OP_SAR:  return ws >>> s;
      OP_ROL:  return (w << s) | (w >> (WIDTH - int'(s)));
      OP_ROR:  return (w >> s) | (w << (WIDTH - int'(s)));
      default: return w;
    endcase
  endfunction

  assign unused_b  = ^req_b[WIDTH-1:LW];
  assign amt       = req_b[LW-1:0];
  assign legal     = (req_opcode == OP_SLL) || (req_opcode == OP_SAR) ||
                     (req_opcode == OP_ROL) || (req_opcode == OP_ROR);
  assign accept    = req_valid && (state == IDLE);
  assign step_amt  = (cnt > STEP_C) ? STEP_C : cnt;
  assign last_step = (cnt <= STEP_C);
  assign shifted   = shift_step(work, op, step_amt);

  assign req_ready   = (state == IDLE);
  assign resp_valid  = (state == DONE);
  assign busy        = (state != IDLE);
  assign resp_result = res;
  assign resp_err    = err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_valid) state_nxt = (!legal || amt == '0) ? DONE : SHIFT;
      SHIFT:   if (last_step) state_nxt = DONE;
      DONE:    if (resp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: capture on accept, walk the working register in SHIFT,
  // publish the result only when DONE is entered so it holds through IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      work <= '0;
      res  <= '0;
      op   <= '0;
      cnt  <= '0;
      err  <= 1'b0;
    end else if (accept) begin
      work <= req_a;
      op   <= req_opcode;
      cnt  <= amt;
      if (!legal) begin
        res <= '0;
        err <= 1'b1;
      end else if (amt == '0) begin
        res <= req_a;
        err <= 1'b0;
      end else begin
        err <= 1'b0;
      end
    end else if (state == SHIFT) begin
      work <= shifted;
      cnt  <= cnt - step_amt;
      if (last_step) res <= shifted;
    end
  end

endmodule
